// File: rtl/axis_descaler.sv
// axis_descaler: recovers a raw sample x = offset + y * 2^(W-2) / scale from a
// scaled AXI-Stream sample y. A restoring divider produces one quotient bit per
// cycle; only one sample is in flight at a time, with full backpressure.
module axis_descaler #(
    parameter int AXIS_TDATA_WIDTH = 14
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic [2*AXIS_TDATA_WIDTH-1:0]   cfg_data,
    input  logic [AXIS_TDATA_WIDTH-1:0]     s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0]     m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            sts_sat
);
    localparam int W  = AXIS_TDATA_WIDTH;
    localparam int DW = 2 * W - 2;          // dividend / quotient width, also divider length
    localparam int RW = 2 * W + 1;          // width of the offset + quotient sum
    localparam int CW = $clog2(DW);

    localparam logic [CW-1:0]        CNT_LAST = CW'(DW - 1);
    localparam logic signed [RW-1:0] R_MAX    = RW'(2 ** (W - 1) - 1);
    localparam logic signed [RW-1:0] R_MIN    = RW'(-(2 ** (W - 1)));
    localparam logic [W-1:0]         O_MAX    = {1'b0, {(W - 1){1'b1}}};
    localparam logic [W-1:0]         O_MIN    = {1'b1, {(W - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            ready_q, ready_d;
    logic            valid_q, valid_d;
    logic [W-1:0]    tdata_q, tdata_d;
    logic            sat_q, sat_d;
    logic            sign_q, sign_d;
    logic            y_neg_q, y_neg_d;
    logic            zero_q, zero_d;
    logic [W-1:0]    offset_q, offset_d;
    logic [W-1:0]    divisor_q, divisor_d;
    logic [DW-1:0]   dividend_q, dividend_d;
    logic [W:0]      rem_q, rem_d;
    logic [DW-1:0]   quot_q, quot_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [W-1:0]    in_scale;
    logic [W-1:0]    in_offset;
    logic [W:0]      y_ext, scale_ext;
    logic [W:0]      y_abs, scale_abs;
    logic [W:0]      rem_shift, rem_sub;
    logic            take;
    logic [RW-1:0]   offset_ext, q_ext, q_signed;
    logic signed [RW-1:0] r_sum;

    // Magnitudes are formed one bit wider than the sample so -2^(W-1) stays exact.
    always_comb begin
        in_scale  = cfg_data[W-1:0];
        in_offset = cfg_data[2*W-1:W];
        y_ext     = {s_axis_tdata[W-1], s_axis_tdata};
        scale_ext = {in_scale[W-1], in_scale};
        y_abs     = s_axis_tdata[W-1] ? ((W + 1)'(0) - y_ext) : y_ext;
        scale_abs = in_scale[W-1] ? ((W + 1)'(0) - scale_ext) : scale_ext;
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_shift = (W + 1)'({rem_q, dividend_q[DW-1]});
        rem_sub   = rem_shift - {1'b0, divisor_q};
        take      = (rem_shift >= {1'b0, divisor_q});
    end

    // Signed recombination of the unsigned quotient with the offset at full width.
    always_comb begin
        offset_ext = {{(W + 1){offset_q[W-1]}}, offset_q};
        q_ext      = {3'b000, quot_q};
        q_signed   = sign_q ? (RW'(0) - q_ext) : q_ext;
        r_sum      = offset_ext + q_signed;
    end

    // Next-state and datapath control for IDLE -> DIV -> FIX -> OUT -> IDLE.
    always_comb begin
        state_d    = state_q;
        tdata_d    = tdata_q;
        sat_d      = sat_q;
        sign_d     = sign_q;
        y_neg_d    = y_neg_q;
        zero_d     = zero_q;
        offset_d   = offset_q;
        divisor_d  = divisor_q;
        dividend_d = dividend_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        cnt_d      = cnt_q;
        ready_d    = 1'b0;
        valid_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (s_axis_tvalid && ready_q) begin
                    sign_d     = s_axis_tdata[W-1] ^ in_scale[W-1];
                    y_neg_d    = s_axis_tdata[W-1];
                    zero_d     = (in_scale == '0);
                    offset_d   = in_offset;
                    divisor_d  = W'(scale_abs);
                    dividend_d = DW'({y_abs, {(W - 2){1'b0}}});
                    rem_d      = '0;
                    quot_d     = '0;
                    cnt_d      = '0;
                    state_d    = (in_scale == '0) ? FIX : DIV;
                end
            end
            DIV: begin
                rem_d      = take ? rem_sub : rem_shift;
                quot_d     = {quot_q[DW-2:0], take};
                dividend_d = {dividend_q[DW-2:0], 1'b0};
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIX: begin
                if (zero_q) begin
                    tdata_d = y_neg_q ? O_MIN : O_MAX;
                    sat_d   = 1'b1;
                end else if (r_sum > R_MAX) begin
                    tdata_d = O_MAX;
                    sat_d   = 1'b1;
                end else if (r_sum < R_MIN) begin
                    tdata_d = O_MIN;
                    sat_d   = 1'b1;
                end else begin
                    tdata_d = r_sum[W-1:0];
                    sat_d   = 1'b0;
                end
                state_d = OUT;
            end
            OUT: begin
                if (m_axis_tready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake flags are registered copies of the upcoming state, so input
        // ready stays low until the first edge after reset is released.
        ready_d = (state_d == IDLE);
        valid_d = (state_d == OUT);
    end

    // State and datapath registers; reset abandons any sample in flight.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
            tdata_q    <= '0;
            sat_q      <= 1'b0;
            sign_q     <= 1'b0;
            y_neg_q    <= 1'b0;
            zero_q     <= 1'b0;
            offset_q   <= '0;
            divisor_q  <= '0;
            dividend_q <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
            tdata_q    <= tdata_d;
            sat_q      <= sat_d;
            sign_q     <= sign_d;
            y_neg_q    <= y_neg_d;
            zero_q     <= zero_d;
            offset_q   <= offset_d;
            divisor_q  <= divisor_d;
            dividend_q <= dividend_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            cnt_q      <= cnt_d;
        end
    end

    assign s_axis_tready = ready_q;
    assign m_axis_tvalid = valid_q;
    assign m_axis_tdata  = tdata_q;
    assign sts_sat       = sat_q;

endmodule

// File: tb/tb_axis_descaler.sv
// Testbench for axis_descaler: directed vector table, randomized samples against
// an arithmetic reference model, and hand-written backpressure / reset sequences.
module tb_axis_descaler;
    localparam int W = 14;

    logic            aclk;
    logic            areset;
    logic [2*W-1:0]  cfg_data;
    logic [W-1:0]    s_axis_tdata;
    logic            s_axis_tvalid;
    logic            s_axis_tready;
    logic [W-1:0]    m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            sts_sat;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int scale;
        int offset;
        int y;
        int exp_x;
        bit exp_sat;
        int exp_lat;
    } vec_t;

    vec_t vecs[13];

    axis_descaler #(.AXIS_TDATA_WIDTH(W)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .cfg_data      (cfg_data),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .sts_sat       (sts_sat)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // x = offset + y * 2^(W-2) / scale, quotient truncated toward zero, clamped to W bits.
    function automatic void ref_model(input int scale, input int offset, input int y,
                                      output int x, output bit sat);
        longint ay, as, q, r, maxv, minv;
        maxv = (longint'(1) << (W - 1)) - 1;
        minv = -(longint'(1) << (W - 1));
        if (scale == 0) begin
            sat = 1'b1;
            x   = (y >= 0) ? int'(maxv) : int'(minv);
        end else begin
            ay = (y < 0) ? -longint'(y) : longint'(y);
            as = (scale < 0) ? -longint'(scale) : longint'(scale);
            q  = (ay << (W - 2)) / as;
            r  = longint'(offset) + (((y < 0) != (scale < 0)) ? -q : q);
            if (r > maxv) begin
                x = int'(maxv); sat = 1'b1;
            end else if (r < minv) begin
                x = int'(minv); sat = 1'b1;
            end else begin
                x = int'(r); sat = 1'b0;
            end
        end
    endfunction

    // Offers one sample, scrambles the inputs after the accept edge, and waits for
    // m_axis_tvalid. lat counts edges from the accept edge (inclusive) until valid is seen.
    task automatic run_sample(input int scale, input int offset, input int y,
                              output int x, output bit sat, output int lat);
        int guard;
        cfg_data      = {W'(offset), W'(scale)};
        s_axis_tdata  = W'(y);
        s_axis_tvalid = 1'b1;
        guard = 0;
        while (!s_axis_tready && guard < 60) begin
            @(posedge aclk); #1;
            guard++;
        end
        chk("in_ready", s_axis_tready, 1);
        @(posedge aclk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = W'($urandom);
        cfg_data      = (2 * W)'($urandom);
        lat = 1;
        while (!m_axis_tvalid && lat < 100) begin
            @(posedge aclk); #1;
            lat++;
        end
        x   = int'($signed(m_axis_tdata));
        sat = sts_sat;
        $display("sample scale=%0d offset=%0d y=%0d -> x=%0d sat=%0d lat=%0d",
                 scale, offset, y, x, sat, lat);
    endtask

    // Consumes the output beat with m_axis_tready high and confirms a single beat.
    task automatic finish_beat();
        m_axis_tready = 1'b1;
        @(posedge aclk); #1;
        chk("one_beat", m_axis_tvalid, 0);
    endtask

    initial begin
        int x, lat, exp_x, sc, of, yy;
        bit sat, exp_sat;

        vecs[0]  = '{4096,     0,  1000,  1000, 1'b0, 28};
        vecs[1]  = '{3000,   100,  1000,  1465, 1'b0, 28};
        vecs[2]  = '{3000,   100, -1000, -1265, 1'b0, 28};
        vecs[3]  = '{-2048,    0,  1000, -2000, 1'b0, 28};
        vecs[4]  = '{-4096,    0, -8192,  8191, 1'b1, 28};
        vecs[5]  = '{1,        0,  8191,  8191, 1'b1, 28};
        vecs[6]  = '{0,        0,    -5, -8192, 1'b1, 2};
        vecs[7]  = '{0,        0,     5,  8191, 1'b1, 2};
        vecs[8]  = '{4096, -8192,    -1, -8192, 1'b1, 28};
        vecs[9]  = '{4096,  8191,     0,  8191, 1'b0, 28};
        vecs[10] = '{-8192,    0, -8192,  4096, 1'b0, 28};
        vecs[11] = '{8191,     0,  8191,  4096, 1'b0, 28};
        vecs[12] = '{5000,     0,    -3,    -2, 1'b0, 28};

        areset        = 1'b1;
        cfg_data      = '0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_in_ready", s_axis_tready, 0);
        chk("rst_out_valid", m_axis_tvalid, 0);
        chk("rst_out_data", m_axis_tdata, 0);
        chk("rst_sat", sts_sat, 0);
        areset = 1'b0;
        #1;
        chk("rel_in_ready_before_edge", s_axis_tready, 0);
        @(posedge aclk); #1;
        chk("rel_in_ready_after_edge", s_axis_tready, 1);

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            run_sample(vecs[i].scale, vecs[i].offset, vecs[i].y, x, sat, lat);
            chk($sformatf("vec%0d_x", i), x, vecs[i].exp_x);
            chk($sformatf("vec%0d_sat", i), sat, vecs[i].exp_sat);
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
            finish_beat();
        end

        // Randomized samples against the reference model
        for (int i = 0; i < 40; i++) begin
            sc = (i % 8 == 3) ? 0 : int'($urandom_range(16383)) - 8192;
            if (i % 5 == 1) sc = int'($urandom_range(64)) - 32;
            of = int'($urandom_range(16383)) - 8192;
            yy = int'($urandom_range(16383)) - 8192;
            ref_model(sc, of, yy, exp_x, exp_sat);
            run_sample(sc, of, yy, x, sat, lat);
            chk($sformatf("rnd%0d_x", i), x, exp_x);
            chk($sformatf("rnd%0d_sat", i), sat, exp_sat);
            chk($sformatf("rnd%0d_lat", i), lat, (sc == 0) ? 2 : 28);
            finish_beat();
        end

        // Backpressure: output held while the input side is busy and scrambled
        m_axis_tready = 1'b0;
        run_sample(3000, 100, 1000, x, sat, lat);
        chk("bp_x", x, 1465);
        for (int i = 0; i < 10; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = W'($urandom);
            cfg_data      = (2 * W)'($urandom);
            @(posedge aclk); #1;
            chk($sformatf("bp_hold%0d_data", i), $signed(m_axis_tdata), 1465);
            chk($sformatf("bp_hold%0d_valid", i), m_axis_tvalid, 1);
            chk($sformatf("bp_hold%0d_in_ready", i), s_axis_tready, 0);
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        @(posedge aclk); #1;
        chk("bp_release_valid", m_axis_tvalid, 0);
        chk("bp_release_in_ready", s_axis_tready, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge aclk); #1;
            chk($sformatf("bp_no_extra%0d", i), m_axis_tvalid, 0);
        end

        // Reset in the middle of a division
        cfg_data      = {W'(0), W'(4096)};
        s_axis_tdata  = W'(1000);
        s_axis_tvalid = 1'b1;
        @(posedge aclk); #1;
        s_axis_tvalid = 1'b0;
        repeat (10) @(posedge aclk);
        #1;
        areset = 1'b1;
        #1;
        chk("mid_rst_valid", m_axis_tvalid, 0);
        chk("mid_rst_in_ready", s_axis_tready, 0);
        chk("mid_rst_data", m_axis_tdata, 0);
        chk("mid_rst_sat", sts_sat, 0);
        @(posedge aclk); #1;
        areset = 1'b0;
        @(posedge aclk); #1;
        chk("post_rst_valid", m_axis_tvalid, 0);
        run_sample(4096, 0, 7, x, sat, lat);
        chk("post_rst_x", x, 7);
        chk("post_rst_sat", sat, 0);
        chk("post_rst_lat", lat, 28);
        finish_beat();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
